pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined two's-complement add/subtract unit for wide datapaths such as the 128-bit CORDIC/trig accumulators. Operands are split into STAGES equal chunks, and the carry ripples one chunk per pipeline stage. Sum, carry-out and signed overflow are produced with a valid/ready handshake on both sides, so a full-width carry never sits in a single combinational path. It generalises the single-cycle combinational full adder to arbitrary width, configurable pipeline depth, subtract mode and backpressure.

## Interface
Parameters:
- W, default 128: operand and sum width. W % STAGES == 0.
- STAGES, default 4: pipeline depth and chunk count. Chunk width C = W/STAGES. STAGES ≥ 1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- io_in_valid  in  1  operand beat offered.
- io_in_ready  out  1  unit accepts the beat this cycle.
- io_in_a  in  W  operand A.
- io_in_b  in  W  operand B.
- io_in_sub  in  1  0: A+B; 1: A−B.
- io_out_valid  out  1  result beat offered.
- io_out_ready  in  1  consumer accepts the result.
- io_out_s  out  W  sum/difference, modulo 2^W.
- io_out_c  out  1  carry-out of the MSB. For subtract this is the no-borrow flag (1 when A ≥ B unsigned).
- io_out_v  out  1  signed overflow.

## Operation
- Effective B: B' = sub ? ~B : B. Initial carry-in = sub.
- Stage k (0..STAGES−1) holds a valid bit and the following fields:
  - result chunks 0..k;
  - unconsumed A and B' chunks k+1..STAGES−1;
  - carry out of chunk k;
  - the MSB-chunk carry-in, retained in the last stage for the overflow calculation.
- Stage 0 computes chunk 0 from the input: {c0, s0} = A[C−1:0] + B'[C−1:0] + sub.
- Stage k computes chunk k from the registered stage k−1 data and its carry: {ck, sk} = A_k + B'_k + c(k−1).
- Outputs are driven from the last stage:
  - io_out_s: the concatenated chunks.
  - io_out_c: the final carry.
  - io_out_v: carry into bit W−1 XOR carry out of bit W−1.
- Handshake: a transfer occurs when valid && ready on that side.
- Stage advance rule (bubble-collapsing): stage k loads when it is empty or stage k+1 loads this cycle. The last stage's "next" is io_out_ready.
- io_in_ready is the load condition of stage 0. It is combinational from the stage valids and io_out_ready. There is no path from io_in_valid to io_in_ready.
- Results emerge in acceptance order. No beat is dropped or duplicated.
- STAGES = 1: the whole W-bit add happens in one stage, registered once.

## Timing
- Reset: all stage valid bits clear. io_out_valid=0, io_out_s=0, io_out_c=0, io_out_v=0 in the cycle after reset is sampled high. io_in_ready=1 once reset deasserts, provided the pipeline is empty.
- Reset mid-operation: all in-flight beats are discarded. No stale result may appear after reset.
- Latency: an input accepted at edge N is presented with io_out_valid=1 after edge N+STAGES−1, i.e. STAGES cycles, when there is no backpressure.
- Throughput: one beat per cycle sustained while io_out_ready=1.
- Backpressure: while io_out_ready=0 and the last stage is valid, the last stage holds. Upstream stages keep filling bubbles.
- io_in_ready falls only when all STAGES stages are valid and io_out_ready=0. Capacity is exactly STAGES beats.
- Simultaneous full pipeline and io_out_ready=1: the output is consumed and a new input is accepted in the same cycle (io_in_ready=1).
- io_out_s, io_out_c and io_out_v stay stable while io_out_valid=1 and io_out_ready=0.

## Test plan
All scenarios use W=128, STAGES=4.
- Wrap with full carry chain: A=2^128−1, B=1, add, accepted at cycle 0 → at cycle 4 io_out_valid=1, s=0, c=1, v=0.
- Subtract with borrow: A=5, B=7, sub → s=2^128−2, c=0, v=0. Then A=7, B=5, sub → s=2, c=1, v=0.
- Signed overflow: A=2^127−1, B=1, add → s=2^127, c=0, v=1. Then A=2^127, B=1, sub → s=2^127−1, c=1, v=1.
- Chunk-boundary carry: A=2^96−1, B=1 → s=2^96, c=0. A=2^32−1, B=2^32−1 → s=2^33−2.
- Backpressure with random operands:
  - Stream 10 beats back-to-back; drop io_out_ready for 5 cycles as the first result appears.
  - io_in_ready deasserts once 4 beats are held.
  - Each result matches the reference model (A±B mod 2^128) in order; no loss or duplication.
  - Outputs are stable during the stall.
- Reset mid-stream: 3 beats in flight, reset asserted 1 cycle → io_out_valid=0 and io_in_ready=1 afterwards. A new beat A=1, B=2 emerges 4 cycles after acceptance with s=3 as the only result.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined W-bit add/subtract: operands split into STAGES chunks, carry ripples one
// chunk per stage, bubble-collapsing valid/ready flow with capacity STAGES beats.

module pipelined_adder_stage #(
  parameter int W = 128,
  parameter int C = 32,
  parameter int K = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ld_i,
  input  logic         vld_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] s_i,
  input  logic         c_i,
  output logic         vld_o,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic [W-1:0] s_o,
  output logic         c_o,
  output logic         v_o
);
  logic [C:0]   sum;
  logic [W-1:0] s_d;
  logic         v_d;
  logic         vld_q, c_q, v_q;
  logic [W-1:0] a_q, b_q, s_q;

  assign sum = {1'b0, a_i[K*C +: C]} + {1'b0, b_i[K*C +: C]} + {{C{1'b0}}, c_i};

  always_comb begin
    s_d = s_i;
    s_d[K*C +: C] = sum[C-1:0];
  end

  // Carry into the chunk MSB is recovered from its sum bit; only the top stage's v is used.
  assign v_d = sum[C] ^ (sum[C-1] ^ a_i[K*C+C-1] ^ b_i[K*C+C-1]);

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else if (ld_i) begin
      vld_q <= vld_i;
      if (vld_i) begin
        a_q <= a_i;
        b_q <= b_i;
        s_q <= s_d;
        c_q <= sum[C];
        v_q <= v_d;
      end
    end
  end

  assign vld_o = vld_q;
  assign a_o   = a_q;
  assign b_o   = b_q;
  assign s_o   = s_q;
  assign c_o   = c_q;
  assign v_o   = v_q;
endmodule

module pipelined_adder #(
  parameter int W      = 128,
  parameter int STAGES = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic [W-1:0] io_in_a,
  input  logic [W-1:0] io_in_b,
  input  logic         io_in_sub,
  output logic         io_out_valid,
  input  logic         io_out_ready,
  output logic [W-1:0] io_out_s,
  output logic         io_out_c,
  output logic         io_out_v
);
  localparam int C = W / STAGES;

  // Link k feeds stage k; link k+1 is stage k's registered output.
  logic [STAGES:0]        vld_l, c_l;
  logic [STAGES:0][W-1:0] a_l, b_l, s_l;
  logic [STAGES-1:0]      v_l;
  logic [STAGES-1:0]      ld;

  assign vld_l[0] = io_in_valid;
  assign a_l[0]   = io_in_a;
  assign b_l[0]   = io_in_sub ? ~io_in_b : io_in_b;
  assign s_l[0]   = '0;
  assign c_l[0]   = io_in_sub;

  // A stage loads when empty or when its successor loads; never depends on io_in_valid.
  always_comb begin
    ld = '0;
    ld[STAGES-1] = ~vld_l[STAGES] | io_out_ready;
    for (int k = STAGES - 2; k >= 0; k--)
      ld[k] = ~vld_l[k+1] | ld[k+1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    pipelined_adder_stage #(.W(W), .C(C), .K(k)) u_stg (
      .clock (clock),
      .reset (reset),
      .ld_i  (ld[k]),
      .vld_i (vld_l[k]),
      .a_i   (a_l[k]),
      .b_i   (b_l[k]),
      .s_i   (s_l[k]),
      .c_i   (c_l[k]),
      .vld_o (vld_l[k+1]),
      .a_o   (a_l[k+1]),
      .b_o   (b_l[k+1]),
      .s_o   (s_l[k+1]),
      .c_o   (c_l[k+1]),
      .v_o   (v_l[k])
    );
  end

  assign io_in_ready  = ld[0];
  assign io_out_valid = vld_l[STAGES];
  assign io_out_s     = s_l[STAGES];
  assign io_out_c     = c_l[STAGES];
  assign io_out_v     = v_l[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (W=128, STAGES=4): corner adds/subtracts,
// backpressure stream against a reference model, and mid-stream reset.
module tb_pipelined_adder;
  localparam int W = 128;
  localparam int STAGES = 4;
  localparam int NB = 10;

  logic         clock = 1'b0;
  logic         reset;
  logic         io_in_valid, io_in_ready, io_in_sub;
  logic [W-1:0] io_in_a, io_in_b, io_out_s;
  logic         io_out_valid, io_out_ready, io_out_c, io_out_v;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  pipelined_adder #(.W(W), .STAGES(STAGES)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_a(io_in_a), .io_in_b(io_in_b), .io_in_sub(io_in_sub),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_s(io_out_s), .io_out_c(io_out_c), .io_out_v(io_out_v)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {v, c, s}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   t;
    logic         v;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    v  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return {v, t};
  endfunction

  // One isolated beat: checks latency edge and hand-computed result.
  task automatic one(input string tag, input logic [W-1:0] a, b, input logic sub,
                     input logic [W-1:0] es, input logic ec, ev);
    @(negedge clock);
    io_in_a = a; io_in_b = b; io_in_sub = sub; io_in_valid = 1'b1; io_out_ready = 1'b1;
    #1 chk({tag, ".in_ready"}, W'(io_in_ready), W'(1));
    @(negedge clock);
    io_in_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk({tag, ".early_valid"}, W'(io_out_valid), W'(0));
    @(negedge clock);
    chk({tag, ".valid"}, W'(io_out_valid), W'(1));
    chk({tag, ".s"}, io_out_s, es);
    chk({tag, ".c"}, W'(io_out_c), W'(ec));
    chk({tag, ".v"}, W'(io_out_v), W'(ev));
    @(negedge clock);
    chk({tag, ".drained"}, W'(io_out_valid), W'(0));
  endtask

  logic [W-1:0] ba [NB];
  logic [W-1:0] bb [NB];
  logic         bs [NB];
  logic [W+1:0] exp_r;
  logic [W-1:0] hold_s;
  logic         hold_c, hold_v;

  initial begin
    int sent, recv, stall_left, cyc, held;
    bit stalled_once, exp_rdy, saw_stall_ready_low;
    logic [W-1:0] one_w;

    reset = 1'b1; io_in_valid = 1'b0; io_out_ready = 1'b1;
    io_in_a = '0; io_in_b = '0; io_in_sub = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst.valid", W'(io_out_valid), W'(0));
    chk("rst.s", io_out_s, '0);
    chk("rst.c", W'(io_out_c), W'(0));
    chk("rst.v", W'(io_out_v), W'(0));
    reset = 1'b0;
    #1 chk("rst.in_ready", W'(io_in_ready), W'(1));

    one_w = '1;
    one("wrap", one_w, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0);
    one("sub_borrow", 128'd5, 128'd7, 1'b1, one_w - 128'd1, 1'b0, 1'b0);
    one("sub_ok", 128'd7, 128'd5, 1'b1, 128'd2, 1'b1, 1'b0);
    one("ovf_add", (128'd1 << 127) - 128'd1, 128'd1, 1'b0, 128'd1 << 127, 1'b0, 1'b1);
    one("ovf_sub", 128'd1 << 127, 128'd1, 1'b1, (128'd1 << 127) - 128'd1, 1'b1, 1'b1);
    one("chunk96", (128'd1 << 96) - 128'd1, 128'd1, 1'b0, 128'd1 << 96, 1'b0, 1'b0);
    one("chunk32", (128'd1 << 32) - 128'd1, (128'd1 << 32) - 128'd1, 1'b0,
        (128'd1 << 33) - 128'd2, 1'b0, 1'b0);

    // Backpressure stream
    for (int i = 0; i < NB; i++) begin
      ba[i] = {$urandom, $urandom, $urandom, $urandom};
      bb[i] = {$urandom, $urandom, $urandom, $urandom};
      bs[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; recv = 0; stall_left = 0; stalled_once = 0; saw_stall_ready_low = 0;
    hold_s = '0; hold_c = 1'b0; hold_v = 1'b0;
    for (cyc = 0; cyc < 100 && recv < NB; cyc++) begin
      @(negedge clock);
      if (io_out_valid && !stalled_once) begin
        stalled_once = 1; stall_left = 5;
        hold_s = io_out_s; hold_c = io_out_c; hold_v = io_out_v;
      end
      io_out_ready = (stall_left == 0);
      if (stall_left > 0) begin
        chk("stall.s", io_out_s, hold_s);
        chk("stall.c", W'(io_out_c), W'(hold_c));
        chk("stall.v", W'(io_out_v), W'(hold_v));
        stall_left--;
      end
      io_in_valid = (sent < NB);
      if (sent < NB) begin
        io_in_a = ba[sent]; io_in_b = bb[sent]; io_in_sub = bs[sent];
      end
      #1;
      held = sent - recv;
      exp_rdy = !(held == STAGES && !io_out_ready);
      chk("bp.in_ready", W'(io_in_ready), W'(exp_rdy));
      if (!exp_rdy && !io_in_ready) saw_stall_ready_low = 1;
      if (io_out_valid && io_out_ready) begin
        exp_r = model(ba[recv], bb[recv], bs[recv]);
        chk($sformatf("bp.s%0d", recv), io_out_s, exp_r[W-1:0]);
        chk($sformatf("bp.c%0d", recv), W'(io_out_c), W'(exp_r[W]));
        chk($sformatf("bp.v%0d", recv), W'(io_out_v), W'(exp_r[W+1]));
        recv++;
      end
      if (io_in_valid && io_in_ready) sent++;
    end
    chk("bp.all_recv", W'(recv), W'(NB));
    chk("bp.ready_fell", W'(saw_stall_ready_low), W'(1));
    @(negedge clock);
    io_in_valid = 1'b0; io_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("bp.no_dup", W'(io_out_valid), W'(0));
    end

    // Mid-stream reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      io_in_a = 128'd100 + 128'(i); io_in_b = 128'd1; io_in_sub = 1'b0; io_in_valid = 1'b1;
    end
    @(negedge clock);
    io_in_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mrst.valid", W'(io_out_valid), W'(0));
    chk("mrst.in_ready", W'(io_in_ready), W'(1));
    one("mrst.beat", 128'd1, 128'd2, 1'b0, 128'd3, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clock);
      chk("mrst.quiet", W'(io_out_valid), W'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
